// File: rtl/cix32_dmem_responder_pkg.sv
// Shared types and constants for the cix32 data-memory responder.
package cix32_dmem_responder_pkg;

    localparam int unsigned CIX32_DMEM_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
    } dmem_req_t;

    // Word offset of a byte address from the window base (32-bit unsigned wrap).
    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        logic [31:0] diff;
        diff = addr - base;
        return diff >> 2;
    endfunction

endpackage

// File: rtl/cix32_byte_ram.sv
// Single-port 2^DEPTH_LOG2 x 32 RAM with per-byte write enables and synchronous read.
module cix32_byte_ram
    import cix32_dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // Byte-lane write or registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < CIX32_DMEM_WORD_BYTES; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/cix32_dmem_responder.sv
// Wait-state data-memory responder for the cix32 dmem req/ready port.
// Optional feature macro: CIX32_DMEM_RAND_WAIT_EN (LFSR-driven extra wait states).
module cix32_dmem_responder
    import cix32_dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err
);

    localparam logic [4:0]  BASE_WAIT = 5'(WAIT_STATES);
    localparam logic [31:0] WORDS     = 32'd1 << DEPTH_LOG2;

    dmem_state_t           state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [4:0]            total_wait;
    dmem_req_t             req_q;
    logic [31:0]           rdata_hold_q;
    logic                  accept;
    logic [31:0]           cur_addr, word_off;
    logic                  cur_we, in_range;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  ram_en, ram_we;
    logic [31:0]           ram_q, resp_data;

    // In IDLE the live bus is decoded so a zero-wait read can start the RAM
    // on the accepting edge; afterwards the registered request is used.
    assign cur_addr = (state_q == IDLE) ? dmem_addr : req_q.addr;
    assign cur_we   = (state_q == IDLE) ? dmem_we   : req_q.we;
    assign word_off = word_offset(cur_addr, BASE_ADDR);
    assign in_range = word_off < WORDS;
    assign word_idx = word_off[DEPTH_LOG2-1:0];

`ifdef CIX32_DMEM_RAND_WAIT_EN
    logic [15:0] lfsr_q;

    assign total_wait = BASE_WAIT + {3'b000, lfsr_q[1:0]};

    // Fibonacci LFSR (taps 16,14,13,11), stepped once per accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else if (accept) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`else
    assign total_wait = BASE_WAIT;
`endif

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_req) begin
                    accept = 1'b1;
                    if (total_wait == 5'd0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = total_wait;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q <= '{addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb, we: dmem_we};
            end
        end
    end

    // Reads are launched on the edge entering RESP; writes land on the RESP edge.
    assign ram_we = (state_q == RESP);
    assign ram_en = in_range && ((state_q == RESP) ? cur_we : (state_d == RESP && !cur_we));

    cix32_byte_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .be   (req_q.wstrb),
        .addr (word_idx),
        .wdata(req_q.wdata),
        .rdata(ram_q)
    );

    assign resp_data = (in_range && !cur_we) ? ram_q : '0;

    // Keep the last response data visible outside RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_hold_q <= '0;
        end else if (state_q == RESP) begin
            rdata_hold_q <= resp_data;
        end
    end

    assign dmem_ready = (state_q == RESP);
    assign dmem_err   = (state_q == RESP) && !in_range;
    assign dmem_rdata = (state_q == RESP) ? resp_data : rdata_hold_q;

endmodule
